if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined CPU. Holds the PC, drives the sequential next-PC candidate into the next-PC 2:1 select, and consumes that select's result as npc.
- Issues single-outstanding requests to instruction memory over a valid/ready handshake.
- Delivers {pc, inst} to the IF/ID segment register through a registered output with a 1-entry skid buffer, and discards wrong-path responses on redirect.

---
 rtl/cpu_fetch_pkg.sv | 21 ++
 rtl/if_fetch_unit_if.sv | 21 ++
 rtl/fetch_skid_buf.sv | 38 +++
 rtl/if_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Saturating increment used by the optional event counters.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel. The fetch unit is the master.
interface if_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ready;
    logic                  resp_valid;
    logic [INST_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding slot behind the fetch output register.
// Flush wins over load; load wins over pop.
module fetch_skid_buf
    import cpu_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [INST_WIDTH-1:0] in_inst,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [INST_WIDTH-1:0] out_inst
);

    // Occupancy and payload of the single entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full     <= 1'b0;
            out_pc   <= '0;
            out_inst <= INST_WIDTH'(NOP_INST);
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full     <= 1'b1;
            out_pc   <= in_pc;
            out_inst <= in_inst;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem requests,
// registered {pc, inst} output backed by a one-entry skid buffer.
// Optional event counters are built when FETCH_PERF_CNT_EN is defined.
//
//  state | meaning
//  IDLE  | dead cycle after reset release
//  REQ   | presenting pc to imem (held back while skid is full)
//  WAIT  | request accepted, response will be delivered
//  DROP  | request accepted but wrong-path, response will be discarded
module if_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    input  logic [ADDR_WIDTH-1:0] npc,
    input  logic                  redirect,
    if_fetch_unit_if.master       imem,
    input  logic                  id_stall,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [INST_WIDTH-1:0] if_inst
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_drop_cnt
`endif
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  skid_full;
    logic [ADDR_WIDTH-1:0] skid_pc;
    logic [INST_WIDTH-1:0] skid_inst;
    logic                  handshake;
    logic                  consume;
    logic                  deliver;
    logic                  skid_load;
    logic                  out_from_skid;
    logic                  out_from_resp;

    assign pc_plus4       = pc + ADDR_WIDTH'(4);
    assign imem.req_addr  = pc;
    assign imem.req_valid = (state == ST_REQ) && !skid_full;
    assign handshake      = imem.req_valid && imem.req_ready;
    assign consume        = if_valid && !id_stall;
    assign deliver        = (state == ST_WAIT) && imem.resp_valid && !redirect;

    // A response only bypasses the skid when the output slot is free this edge;
    // an older skid entry always goes out first.
    assign out_from_skid  = consume && skid_full;
    assign out_from_resp  = deliver && (!if_valid || (consume && !skid_full));
    assign skid_load      = deliver && if_valid && (id_stall || skid_full);

    fetch_skid_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .load     (skid_load),
        .pop      (out_from_skid),
        .flush    (redirect),
        .in_pc    (req_pc),
        .in_inst  (imem.resp_data),
        .full     (skid_full),
        .out_pc   (skid_pc),
        .out_inst (skid_inst)
    );

    // Fetch FSM, PC update and output slot; redirect overrides everything else.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            req_pc   <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= INST_WIDTH'(NOP_INST);
        end else if (redirect) begin
            pc       <= npc;
            if_valid <= 1'b0;
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ:  state <= handshake ? ST_DROP : ST_REQ;
                ST_WAIT: state <= imem.resp_valid ? ST_REQ : ST_DROP;
                ST_DROP: state <= imem.resp_valid ? ST_REQ : ST_DROP;
                default: state <= ST_IDLE;
            endcase
        end else begin
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ: begin
                    if (handshake) begin
                        req_pc <= pc;
                        pc     <= npc;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: if (imem.resp_valid) state <= ST_REQ;
                ST_DROP: if (imem.resp_valid) state <= ST_REQ;
                default: state <= ST_IDLE;
            endcase
            if (out_from_skid) begin
                if_valid <= 1'b1;
                if_pc    <= skid_pc;
                if_inst  <= skid_inst;
            end else if (out_from_resp) begin
                if_valid <= 1'b1;
                if_pc    <= req_pc;
                if_inst  <= imem.resp_data;
            end else if (consume) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [1:0] drop_inc;

    // Discarded responses plus entries thrown away by a redirect flush.
    always_comb begin
        drop_inc = 2'd0;
        if (imem.resp_valid && ((state == ST_DROP) || (state == ST_WAIT && redirect)))
            drop_inc = drop_inc + 2'd1;
        if (redirect && if_valid && !consume)
            drop_inc = drop_inc + 2'd1;
        if (redirect && skid_full)
            drop_inc = drop_inc + 2'd1;
    end

    // Saturating delivered/dropped instruction counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            perf_fetch_cnt <= sat_add(perf_fetch_cnt, {1'b0, consume});
            perf_drop_cnt  <= sat_add(perf_drop_cnt, drop_inc);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_if_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        redirect;
    logic        id_stall;
    logic [31:0] tgt;
    logic [31:0] npc;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    if_fetch_unit_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) imem ();

    // The external next-PC select: sequential path unless a redirect is taken.
    assign npc = redirect ? tgt : pc_plus4;

    if_fetch_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .pc_plus4       (pc_plus4),
        .npc            (npc),
        .redirect       (redirect),
        .imem           (imem),
        .id_stall       (id_stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt),
`endif
        .if_inst        (if_inst)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc;
    logic [31:0] req_log[$];
    logic [31:0] out_log[$];
    int          out_cyc[$];

    // memory environment
    logic        mem_ready;
    int          lat;
    int          mem_cnt;
    logic [31:0] mem_addr;

    // reference model
    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    logic        m_busy;
    logic        m_wrong;
    logic        m_started;
    logic [31:0] m_fetch;
    logic [31:0] m_drop;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_q(input string name, input logic [31:0] qq[$], input int idx,
                         input logic [31:0] exp);
        if (idx < qq.size()) begin
            chk(name, qq[idx], exp);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL %s: entry %0d absent (have %0d) expected %h", name, idx, qq.size(), exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc      = 32'h0000_3000;
        m_req_pc  = '0;
        m_busy    = 1'b0;
        m_wrong   = 1'b0;
        m_started = 1'b0;
        m_fetch   = '0;
        m_drop    = '0;
    endtask

    // One clock cycle: entered and left at a falling edge with inputs already set.
    task automatic step();
        logic        exp_rv;
        logic        pop;
        logic        resp_here;
        logic        hs;
        logic        dut_hs;
        logic [31:0] dut_addr;
        ent_t        e;
        imem.req_ready  = mem_ready;
        imem.resp_valid = (mem_cnt == 1);
        imem.resp_data  = inst_of(mem_addr);
        dut_hs   = 1'b0;
        dut_addr = '0;
        if (rstn) begin
            #1;
            exp_rv = m_started && !m_busy && (q.size() < 2);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("req_valid", 32'(imem.req_valid), 32'(exp_rv));
            if (exp_rv) chk("req_addr", imem.req_addr, m_pc);
            chk("if_valid", 32'(if_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("if_pc", if_pc, q[0].pc);
                chk("if_inst", if_inst, q[0].inst);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch", perf_fetch_cnt, m_fetch);
            chk("perf_drop", perf_drop_cnt, m_drop);
`endif
            dut_hs   = imem.req_valid && imem.req_ready;
            dut_addr = imem.req_addr;
            if (dut_hs) req_log.push_back(dut_addr);
            if (if_valid && !id_stall) begin
                out_log.push_back(if_pc);
                out_cyc.push_back(cyc);
            end
            pop       = (q.size() > 0) && !id_stall;
            resp_here = m_busy && imem.resp_valid;
            hs        = exp_rv && mem_ready;
            if (pop) m_fetch++;
            if (redirect) begin
                if (resp_here) m_drop++;
                m_drop = m_drop + 32'(q.size()) - (pop ? 32'd1 : 32'd0);
                q.delete();
                m_pc = tgt;
                if (hs) begin
                    m_busy  = 1'b1;
                    m_wrong = 1'b1;
                end else if (resp_here) begin
                    m_busy = 1'b0;
                end else if (m_busy) begin
                    m_wrong = 1'b1;
                end
            end else begin
                if (pop) void'(q.pop_front());
                if (resp_here) begin
                    m_busy = 1'b0;
                    if (m_wrong) begin
                        m_drop++;
                    end else begin
                        e.pc   = m_req_pc;
                        e.inst = inst_of(m_req_pc);
                        q.push_back(e);
                    end
                end
                if (hs) begin
                    m_busy   = 1'b1;
                    m_wrong  = 1'b0;
                    m_req_pc = m_pc;
                    m_pc     = m_pc + 32'd4;
                end
            end
            m_started = 1'b1;
            cyc++;
        end
        @(posedge clk);
        if (mem_cnt > 0) mem_cnt--;
        if (dut_hs) begin
            mem_cnt  = lat;
            mem_addr = dut_addr;
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        cyc = 0;
        req_log.delete();
        out_log.delete();
        out_cyc.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_if_pc"}, if_pc, 32'd0);
        chk({tag, "_if_inst"}, if_inst, 32'h0000_0013);
        chk({tag, "_req_valid"}, 32'(imem.req_valid), 32'd0);
        chk({tag, "_pc_plus4"}, pc_plus4, 32'h0000_3004);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        redirect  = 1'b0;
        id_stall  = 1'b0;
        tgt       = '0;
        mem_ready = 1'b1;
        mem_cnt   = 0;
        mem_addr  = '0;
        lat       = 1;
        model_reset();
        step();
        step();
        chk_reset_vals("rst");
        rstn = 1'b1;
        clear_logs();
    endtask

    initial begin
        cyc = 0;
        // 1: plain sequential fetch, 1-cycle memory
        do_reset();
        for (int i = 0; i < 8; i++) step();
        chk_q("t1_req0", req_log, 0, 32'h3000);
        chk_q("t1_req1", req_log, 1, 32'h3004);
        chk_q("t1_req2", req_log, 2, 32'h3008);
        chk_q("t1_out0", out_log, 0, 32'h3000);
        chk_q("t1_out1", out_log, 1, 32'h3004);
        chk_q("t1_out2", out_log, 2, 32'h3008);
        chk("t1_first_cyc", 32'(out_cyc.size() > 0 ? out_cyc[0] : -1), 32'd3);
        chk("t1_spacing", 32'(out_cyc.size() > 1 ? out_cyc[1] - out_cyc[0] : -1), 32'd2);

        // 2: six-cycle stall fills the skid and blocks new requests
        do_reset();
        for (int i = 0; i < 11; i++) begin
            id_stall = (i >= 3) && (i <= 8);
            if (i == 9) begin
                chk("t2_hold_pc", if_pc, 32'h3000);
                chk("t2_hold_valid", 32'(if_valid), 32'd1);
                chk("t2_req_cnt", 32'(req_log.size()), 32'd2);
            end
            if (i == 10) chk("t2_next_pc", if_pc, 32'h3004);
            step();
        end
        id_stall = 1'b0;
        chk_q("t2_req2", req_log, 2, 32'h3008);
        chk_q("t2_out0", out_log, 0, 32'h3000);
        chk_q("t2_out1", out_log, 1, 32'h3004);
        chk("t2_out_cnt", 32'(out_log.size()), 32'd2);

        // 3: redirect while waiting on 0x3008 (2-cycle memory)
        do_reset();
        lat = 2;
        for (int i = 0; i < 12; i++) begin
            id_stall = (i == 7);
            redirect = (i == 8);
            tgt      = 32'h3100;
            if (i == 9) chk("t3_valid_drop", 32'(if_valid), 32'd0);
            step();
        end
        redirect = 1'b0;
        chk_q("t3_req2", req_log, 2, 32'h3008);
        chk_q("t3_req3", req_log, 3, 32'h3100);
        chk("t3_out_cnt", 32'(out_log.size()), 32'd2);
`ifdef FETCH_PERF_CNT_EN
        chk("t3_perf_drop", perf_drop_cnt, 32'd1);
        chk("t3_perf_fetch", perf_fetch_cnt, 32'(out_log.size()));
`endif

        // 4: redirect on a handshake cycle, then on a response cycle
        do_reset();
        for (int i = 0; i < 9; i++) begin
            redirect = (i == 1) || (i == 4);
            tgt      = (i == 1) ? 32'h4000 : 32'h5000;
            if (i == 7) chk("t4_inst", if_inst, 32'hA5A5_5000);
            step();
        end
        redirect = 1'b0;
        chk_q("t4_req0", req_log, 0, 32'h3000);
        chk_q("t4_req1", req_log, 1, 32'h4000);
        chk_q("t4_req2", req_log, 2, 32'h5000);
        chk_q("t4_out0", out_log, 0, 32'h5000);
        chk("t4_out_cnt", 32'(out_log.size()), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("t4_perf_drop", perf_drop_cnt, 32'd2);
`endif

        // 5: reset in WAIT, stale response lands after release
        do_reset();
        lat = 3;
        step();
        step();
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_vals("t5_async");
        model_reset();
        step();
        rstn = 1'b1;
        lat  = 1;
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) chk("t5_late_ignored", 32'(if_valid), 32'd0);
            step();
        end
        chk_q("t5_req0", req_log, 0, 32'h3000);
        chk_q("t5_out0", out_log, 0, 32'h3000);
        chk("t5_out_cyc", 32'(out_cyc.size() > 0 ? out_cyc[0] : -1), 32'd3);

        // 7: redirect from IDLE to the top of memory, back-pressure, redirect in REQ
        do_reset();
        for (int i = 0; i < 6; i++) begin
            redirect  = (i == 0) || (i == 2);
            tgt       = (i == 0) ? 32'hFFFF_FFFC : 32'h0000_0100;
            mem_ready = (i >= 3);
            if (i == 1) begin
                chk("t7_wrap", pc_plus4, 32'h0000_0000);
                chk("t7_req_addr", imem.req_addr, 32'hFFFF_FFFC);
            end
            step();
        end
        redirect = 1'b0;
        chk_q("t7_req0", req_log, 0, 32'h0000_0100);
        chk_q("t7_out0", out_log, 0, 32'h0000_0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
